// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: register alias table with branch checkpoints
// Rev 1.0 - one rename per cycle, one-cycle mispredict restore, RRAT flush restore
`default_nettype none

module rename_map_ckpt #(
  parameter int NUM_ARCH = 34,
  parameter int PTAG_W   = 6,
  parameter int NUM_CKPT = 4,
  localparam int CK_W    = $clog2(NUM_CKPT)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_src1,
  input  logic [5:0]                 in_src2,
  input  logic [5:0]                 in_dst,
  input  logic                       in_dst_wr,
  input  logic                       in_is_br,
  input  logic                       fl_valid,
  input  logic [PTAG_W-1:0]          fl_tag,
  output logic                       fl_pop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PTAG_W-1:0]          out_src1_tag,
  output logic [PTAG_W-1:0]          out_src2_tag,
  output logic [PTAG_W-1:0]          out_dst_tag,
  output logic [PTAG_W-1:0]          out_old_tag,
  output logic [CK_W-1:0]            out_ckpt_id,
  output logic                       out_is_br,
  input  logic                       flush,
  input  logic [NUM_ARCH*PTAG_W-1:0] rrat_map,
  input  logic                       br_valid,
  input  logic [CK_W-1:0]            br_id,
  input  logic                       br_mispred,
  output logic                       ckpt_full
);

  localparam logic [CK_W:0] C_CKPT_N = (CK_W+1)'(NUM_CKPT);

  logic [PTAG_W-1:0] r_map  [NUM_ARCH];
  logic [PTAG_W-1:0] r_ckpt [NUM_CKPT][NUM_ARCH];
  logic [PTAG_W-1:0] w_map_next [NUM_ARCH];
  logic [CK_W-1:0]   r_head, r_tail;
  logic [CK_W:0]     r_count;

  logic              w_need_tag, w_dst_in, w_fire, w_fire_br, w_map_wr;
  logic [CK_W-1:0]   w_br_dist;
  logic              w_br_live, w_mispred, w_resolve;
  logic [PTAG_W-1:0] w_src1_tag, w_src2_tag, w_old_tag;

  assign w_need_tag = in_dst_wr & (in_dst != 6'd0);
  assign w_dst_in   = int'(in_dst) < NUM_ARCH;

  assign in_ready = !flush & !(br_valid & br_mispred) & (!out_valid | out_ready)
                  & (!w_need_tag | fl_valid) & (!in_is_br | (r_count < C_CKPT_N));
  assign w_fire    = in_valid & in_ready;
  assign w_fire_br = w_fire & in_is_br;
  assign fl_pop    = w_fire & w_need_tag;
  assign w_map_wr  = w_fire & w_need_tag & w_dst_in;

  // A checkpoint id is live when its distance from head is inside the live window.
  assign w_br_dist = br_id - r_head;
  assign w_br_live = {1'b0, w_br_dist} < r_count;
  assign w_mispred = br_valid & br_mispred & w_br_live;
  assign w_resolve = br_valid & !br_mispred & (br_id == r_head) & (r_count != '0);

  assign w_src1_tag = (int'(in_src1) < NUM_ARCH) ? r_map[in_src1] : '0;
  assign w_src2_tag = (int'(in_src2) < NUM_ARCH) ? r_map[in_src2] : '0;
  assign w_old_tag  = w_dst_in ? r_map[in_dst] : '0;

  always_comb begin
    for (int i = 0; i < NUM_ARCH; i++) w_map_next[i] = r_map[i];
    if (w_map_wr) w_map_next[in_dst] = fl_tag;
  end

  // Entry 0 is hard-wired to tag 0 and never written.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) r_map[i] <= PTAG_W'(i);
    end else if (flush) begin
      for (int i = 1; i < NUM_ARCH; i++) r_map[i] <= rrat_map[i*PTAG_W +: PTAG_W];
    end else if (w_mispred) begin
      for (int i = 1; i < NUM_ARCH; i++) r_map[i] <= r_ckpt[br_id][i];
    end else if (w_map_wr) begin
      for (int i = 1; i < NUM_ARCH; i++) r_map[i] <= w_map_next[i];
    end
  end

  // Snapshot includes the branch's own destination update.
  always_ff @(posedge CLK) begin
    if (w_fire_br) begin
      for (int i = 0; i < NUM_ARCH; i++) r_ckpt[r_tail][i] <= w_map_next[i];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispred) begin
      r_tail  <= br_id;
      r_count <= {1'b0, w_br_dist};
    end else begin
      if (w_resolve) r_head <= r_head + 1'b1;
      if (w_fire_br) r_tail <= r_tail + 1'b1;
      case ({w_fire_br, w_resolve})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      out_src1_tag <= '0;
      out_src2_tag <= '0;
      out_dst_tag  <= '0;
      out_old_tag  <= '0;
      out_ckpt_id  <= '0;
      out_is_br    <= 1'b0;
    end else if (flush | w_mispred) begin
      out_valid <= 1'b0;
    end else if (w_fire) begin
      out_valid    <= 1'b1;
      out_src1_tag <= w_src1_tag;
      out_src2_tag <= w_src2_tag;
      out_dst_tag  <= w_need_tag ? fl_tag : '0;
      out_old_tag  <= w_need_tag ? w_old_tag : '0;
      out_ckpt_id  <= in_is_br ? r_tail : '0;
      out_is_br    <= in_is_br;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ckpt_full = (r_count == C_CKPT_N);

endmodule

`default_nettype wire

// File: tb/tb_rename_map_ckpt.sv
// tb_rename_map_ckpt: directed self-checking bench for rename_map_ckpt
// Rev 1.0
`default_nettype none

module tb_rename_map_ckpt;

  localparam int NUM_ARCH = 34;
  localparam int PTAG_W   = 6;
  localparam int NUM_CKPT = 4;
  localparam int CK_W     = 2;

  logic                       CLK, RESET;
  logic                       in_valid, in_ready;
  logic [5:0]                 in_src1, in_src2, in_dst;
  logic                       in_dst_wr, in_is_br;
  logic                       fl_valid, fl_pop;
  logic [PTAG_W-1:0]          fl_tag;
  logic                       out_valid, out_ready;
  logic [PTAG_W-1:0]          out_src1_tag, out_src2_tag, out_dst_tag, out_old_tag;
  logic [CK_W-1:0]            out_ckpt_id;
  logic                       out_is_br;
  logic                       flush;
  logic [NUM_ARCH*PTAG_W-1:0] rrat_map;
  logic                       br_valid, br_mispred;
  logic [CK_W-1:0]            br_id;
  logic                       ckpt_full;

  int n_tests = 0;
  int n_fail  = 0;

  rename_map_ckpt #(.NUM_ARCH(NUM_ARCH), .PTAG_W(PTAG_W), .NUM_CKPT(NUM_CKPT)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .in_dst_wr(in_dst_wr), .in_is_br(in_is_br),
    .fl_valid(fl_valid), .fl_tag(fl_tag), .fl_pop(fl_pop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1_tag(out_src1_tag), .out_src2_tag(out_src2_tag),
    .out_dst_tag(out_dst_tag), .out_old_tag(out_old_tag),
    .out_ckpt_id(out_ckpt_id), .out_is_br(out_is_br),
    .flush(flush), .rrat_map(rrat_map),
    .br_valid(br_valid), .br_id(br_id), .br_mispred(br_mispred),
    .ckpt_full(ckpt_full)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_src1 = 0; in_src2 = 0; in_dst = 0;
    in_dst_wr = 0; in_is_br = 0; fl_valid = 1; fl_tag = 0;
    out_ready = 1; flush = 0; br_valid = 0; br_id = 0; br_mispred = 0;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
  endtask

  task automatic instr(input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d,
                       input logic wr, input logic br, input logic [PTAG_W-1:0] tag);
    in_valid = 1; in_src1 = s1; in_src2 = s2; in_dst = d;
    in_dst_wr = wr; in_is_br = br; fl_tag = tag;
  endtask

  initial begin
    for (int i = 0; i < NUM_ARCH; i++) rrat_map[i*PTAG_W +: PTAG_W] = PTAG_W'(i + 20);
    idle();
    RESET = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ckpt_full", ckpt_full, 0);
    check("rst_dst_tag", out_dst_tag, 0);
    tick();
    tick();
    RESET = 0;

    // 1: r3 <- r1, r2 with tag 40
    instr(1, 2, 3, 1, 0, 40);
    #1;
    check("t1_in_ready", in_ready, 1);
    check("t1_fl_pop", fl_pop, 1);
    check("t1_out_valid_pre", out_valid, 0);
    tick();
    in_valid = 0;
    check("t1_out_valid", out_valid, 1);
    check("t1_src1", out_src1_tag, 1);
    check("t1_src2", out_src2_tag, 2);
    check("t1_dst", out_dst_tag, 40);
    check("t1_old", out_old_tag, 3);

    // 2: dependent chain, r0 destination, src == dst
    do_reset();
    instr(1, 0, 3, 1, 0, 40);
    tick();
    instr(3, 0, 4, 1, 0, 41);
    tick();
    check("t2_src1_dep", out_src1_tag, 40);
    check("t2_old4", out_old_tag, 4);
    instr(2, 0, 0, 1, 0, 50);
    #1;
    check("t2_r0_fl_pop", fl_pop, 0);
    tick();
    check("t2_r0_dst", out_dst_tag, 0);
    check("t2_r0_old", out_old_tag, 0);
    instr(6, 0, 6, 1, 0, 42);
    tick();
    check("t2_self_src", out_src1_tag, 6);
    instr(6, 0, 7, 1, 0, 43);
    tick();
    check("t2_self_next", out_src1_tag, 42);
    in_valid = 0;

    // 3: free list empty, then output backpressure
    do_reset();
    instr(0, 0, 5, 1, 0, 44);
    fl_valid = 0;
    #1;
    check("t3_stall_ready", in_ready, 0);
    tick();
    check("t3_stall_valid", out_valid, 0);
    fl_valid = 1;
    fl_tag = 45;
    out_ready = 0;
    tick();
    check("t3_fire_dst", out_dst_tag, 45);
    instr(5, 0, 8, 1, 0, 46);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_ready", in_ready, 0);
      tick();
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_dst", out_dst_tag, 45);
      check("t3_hold_old", out_old_tag, 5);
    end
    out_ready = 1;
    #1;
    check("t3_release_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("t3_after_src1", out_src1_tag, 45);
    check("t3_after_dst", out_dst_tag, 46);

    // 4: fill checkpoints, resolve head, refill
    do_reset();
    for (int k = 0; k < NUM_CKPT; k++) begin
      instr(1, 2, 0, 0, 1, 0);
      tick();
      check("t4_ckpt_id", out_ckpt_id, k);
      check("t4_is_br", out_is_br, 1);
    end
    check("t4_full", ckpt_full, 1);
    check("t4_5th_stall", in_ready, 0);
    br_valid = 1; br_id = 0; br_mispred = 0;
    #1;
    check("t4_resolve_stall", in_ready, 0);
    tick();
    br_valid = 0;
    check("t4_not_full", ckpt_full, 0);
    check("t4_5th_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("t4_5th_valid", out_valid, 1);
    check("t4_5th_id", out_ckpt_id, 0);
    check("t4_full_again", ckpt_full, 1);

    // 5: mispredict restores map and ckpt pointers
    do_reset();
    instr(1, 0, 0, 0, 1, 0);
    tick();
    check("t5_br_id", out_ckpt_id, 0);
    instr(0, 0, 5, 1, 0, 50);
    tick();
    check("t5_dst", out_dst_tag, 50);
    check("t5_old", out_old_tag, 5);
    in_valid = 0;
    out_ready = 0;
    br_valid = 1; br_id = 0; br_mispred = 1;
    #1;
    check("t5_mp_ready", in_ready, 0);
    tick();
    br_valid = 0; br_mispred = 0;
    check("t5_mp_valid", out_valid, 0);
    check("t5_mp_full", ckpt_full, 0);
    out_ready = 1;
    instr(5, 0, 0, 0, 1, 0);
    tick();
    in_valid = 0;
    check("t5_restored_src", out_src1_tag, 5);
    check("t5_restored_id", out_ckpt_id, 0);

    // 6: flush loads the retirement map
    do_reset();
    instr(7, 0, 7, 1, 0, 60);
    flush = 1;
    #1;
    check("t6_flush_ready", in_ready, 0);
    check("t6_flush_pop", fl_pop, 0);
    tick();
    flush = 0;
    check("t6_flush_valid", out_valid, 0);
    tick();
    in_valid = 0;
    check("t6_src1", out_src1_tag, 27);
    check("t6_old", out_old_tag, 27);
    check("t6_dst", out_dst_tag, 60);

    // 7: asynchronous reset mid-operation
    do_reset();
    instr(3, 0, 3, 1, 0, 33);
    tick();
    in_valid = 0;
    check("t7_pre_valid", out_valid, 1);
    #2;
    RESET = 1;
    #1;
    check("t7_async_valid", out_valid, 0);
    check("t7_async_dst", out_dst_tag, 0);
    tick();
    RESET = 0;
    instr(3, 0, 0, 0, 0, 0);
    tick();
    in_valid = 0;
    check("t7_map_reset", out_src1_tag, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
